// File: rtl/countdown_timer.sv
// Loadable down-counter with prescaler, pause, periodic reload
// and a one-cycle terminal-count pulse with a sticky expired flag.
module countdown_timer #(
  parameter int WIDTH = 8,
  parameter int PS_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] load_val,
  input  logic [PS_W-1:0]  prescale,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expired
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [PS_W-1:0]  psc;
  logic [PS_W-1:0]  rl_ps;
  logic [WIDTH-1:0] rl_val;
  logic             rl_auto;
  logic             zero_pend;

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      psc       <= '0;
      done      <= 1'b0;
      expired   <= 1'b0;
      rl_val    <= '0;
      rl_ps     <= '0;
      rl_auto   <= 1'b0;
      zero_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state     <= IDLE;
        count     <= '0;
        psc       <= '0;
        zero_pend <= 1'b0;
      end else if (start) begin
        rl_val    <= load_val;
        rl_ps     <= prescale;
        rl_auto   <= auto_reload;
        count     <= load_val;
        psc       <= '0;
        expired   <= 1'b0;
        state     <= (load_val != '0) ? RUN : IDLE;
        zero_pend <= (load_val == '0);
      end else begin
        zero_pend <= 1'b0;
        // A zero load expires one edge after the start edge.
        if (zero_pend) begin
          done    <= 1'b1;
          expired <= 1'b1;
        end
        if (state == RUN && !pause) begin
          if (psc != rl_ps) begin
            psc <= psc + PS_W'(1);
          end else begin
            psc <= '0;
            if (count > WIDTH'(1)) begin
              count <= count - WIDTH'(1);
            end else if (count == WIDTH'(1)) begin
              done    <= 1'b1;
              expired <= 1'b1;
              if (rl_auto) begin
                count <= rl_val;
              end else begin
                count <= '0;
                state <= IDLE;
              end
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
// Inputs change 1ns after a rising edge; outputs sampled there.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] load_val;
  logic [3:0] prescale;
  logic       start;
  logic       stop;
  logic       pause;
  logic       auto_reload;
  logic [7:0] count;
  logic       busy;
  logic       done;
  logic       expired;

  int pass_cnt = 0;
  int total    = 0;

  countdown_timer #(.WIDTH(8), .PS_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .load_val(load_val),
    .prescale(prescale),
    .start(start),
    .stop(stop),
    .pause(pause),
    .auto_reload(auto_reload),
    .count(count),
    .busy(busy),
    .done(done),
    .expired(expired)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [7:0] l, input logic [3:0] p,
                      input logic ar);
    load_val    = l;
    prescale    = p;
    auto_reload = ar;
    start       = 1'b1;
    step();
    start       = 1'b0;
  endtask

  task automatic test_reset();
    kick(8'd2, 4'd0, 1'b1);
    step();
    step();
    step();
    total++;
    if (expired !== 1'b1 || busy !== 1'b1)
      $display("FAIL reset_pre: expired=%b busy=%b want 1 1", expired, busy);
    else pass_cnt++;
    rst = 1'b1;
    step();
    total++;
    if ({count, busy, done, expired} !== 11'd0)
      $display("FAIL reset_state: count=%0d busy=%b done=%b exp=%b want 0",
               count, busy, done, expired);
    else pass_cnt++;
    step();
    rst = 1'b0;
    step();
    total++;
    if ({count, busy, done, expired} !== 11'd0)
      $display("FAIL reset_after: count=%0d busy=%b done=%b exp=%b want 0",
               count, busy, done, expired);
    else pass_cnt++;
  endtask

  task automatic test_one_shot();
    kick(8'd3, 4'd0, 1'b0);
    total++;
    if (count !== 8'd3 || busy !== 1'b1 || done !== 1'b0 || expired !== 1'b0)
      $display("FAIL oneshot_load: count=%0d busy=%b done=%b exp=%b want 3 1 0 0",
               count, busy, done, expired);
    else pass_cnt++;
    for (int i = 2; i >= 0; i--) begin
      step();
      total++;
      if (count !== 8'(i) || done !== (i == 0) || busy !== (i != 0))
        $display("FAIL oneshot_run: count=%0d done=%b busy=%b want %0d %b %b",
                 count, done, busy, i, (i == 0), (i != 0));
      else pass_cnt++;
    end
    step();
    total++;
    if (done !== 1'b0 || expired !== 1'b1 || count !== 8'd0)
      $display("FAIL oneshot_after: done=%b exp=%b count=%0d want 0 1 0",
               done, expired, count);
    else pass_cnt++;
  endtask

  task automatic test_prescaled();
    logic [7:0] exp_c;
    kick(8'd2, 4'd3, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      step();
      exp_c = (c < 4) ? 8'd2 : (c < 8) ? 8'd1 : 8'd0;
      total++;
      if (count !== exp_c || done !== (c == 8))
        $display("FAIL prescaled c=%0d: count=%0d done=%b want %0d %b",
                 c, count, done, exp_c, (c == 8));
      else pass_cnt++;
    end
  endtask

  task automatic test_long();
    int bad = 0;
    kick(8'd255, 4'd0, 1'b0);
    for (int c = 1; c <= 255; c++) begin
      step();
      if (count !== 8'(255 - c) || done !== (c == 255)) bad++;
    end
    total++;
    if (bad != 0)
      $display("FAIL long_run: bad_cycles=%0d want 0", bad);
    else pass_cnt++;
    step();
    total++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL long_underflow: count=%0d busy=%b done=%b want 0 0 0",
               count, busy, done);
    else pass_cnt++;
  endtask

  task automatic test_periodic();
    logic [7:0] exp_c;
    kick(8'd3, 4'd0, 1'b1);
    for (int c = 1; c <= 9; c++) begin
      if (c == 4) auto_reload = 1'b0;
      step();
      exp_c = 8'(3 - (c % 3));
      total++;
      if (count !== exp_c || done !== (c % 3 == 0) || busy !== 1'b1)
        $display("FAIL periodic c=%0d: count=%0d done=%b busy=%b want %0d %b 1",
                 c, count, done, busy, exp_c, (c % 3 == 0));
      else pass_cnt++;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    total++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || expired !== 1'b1)
      $display("FAIL periodic_stop: count=%0d busy=%b done=%b exp=%b want 0 0 0 1",
               count, busy, done, expired);
    else pass_cnt++;
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0)
      $display("FAIL periodic_stop2: done=%b busy=%b want 0 0", done, busy);
    else pass_cnt++;
  endtask

  task automatic test_pause();
    kick(8'd4, 4'd0, 1'b0);
    step();
    pause = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      total++;
      if (count !== 8'd3 || busy !== 1'b1 || done !== 1'b0)
        $display("FAIL pause_hold: count=%0d busy=%b done=%b want 3 1 0",
                 count, busy, done);
      else pass_cnt++;
    end
    pause = 1'b0;
    for (int c = 2; c >= 0; c--) begin
      step();
      total++;
      if (count !== 8'(c) || done !== (c == 0))
        $display("FAIL pause_resume: count=%0d done=%b want %0d %b",
                 count, done, c, (c == 0));
      else pass_cnt++;
    end
    pause = 1'b1;
    kick(8'd2, 4'd0, 1'b0);
    step();
    total++;
    if (count !== 8'd2 || busy !== 1'b1)
      $display("FAIL pause_start: count=%0d busy=%b want 2 1", count, busy);
    else pass_cnt++;
    pause = 1'b0;
    step();
    total++;
    if (count !== 8'd1)
      $display("FAIL pause_release: count=%0d want 1", count);
    else pass_cnt++;
  endtask

  task automatic test_start_stop();
    kick(8'd5, 4'd0, 1'b0);
    load_val = 8'd7;
    start    = 1'b1;
    stop     = 1'b1;
    step();
    start    = 1'b0;
    stop     = 1'b0;
    total++;
    if (count !== 8'd0 || busy !== 1'b0 || done !== 1'b0)
      $display("FAIL start_stop: count=%0d busy=%b done=%b want 0 0 0",
               count, busy, done);
    else pass_cnt++;
  endtask

  task automatic test_zero_load();
    kick(8'd0, 4'd0, 1'b0);
    total++;
    if (busy !== 1'b0 || count !== 8'd0 || done !== 1'b0 || expired !== 1'b0)
      $display("FAIL zero_k: busy=%b count=%0d done=%b exp=%b want 0 0 0 0",
               busy, count, done, expired);
    else pass_cnt++;
    step();
    total++;
    if (busy !== 1'b0 || done !== 1'b1 || expired !== 1'b1)
      $display("FAIL zero_k1: busy=%b done=%b exp=%b want 0 1 1",
               busy, done, expired);
    else pass_cnt++;
    step();
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || expired !== 1'b1)
      $display("FAIL zero_k2: busy=%b done=%b exp=%b want 0 0 1",
               busy, done, expired);
    else pass_cnt++;
    kick(8'd2, 4'd0, 1'b0);
    total++;
    if (expired !== 1'b0 || busy !== 1'b1)
      $display("FAIL zero_clear: exp=%b busy=%b want 0 1", expired, busy);
    else pass_cnt++;
    step();
    step();
  endtask

  task automatic test_back_to_back();
    load_val = 8'd9;
    start    = 1'b1;
    step();
    load_val = 8'd5;
    step();
    load_val = 8'd2;
    step();
    start    = 1'b0;
    total++;
    if (count !== 8'd2)
      $display("FAIL b2b_load: count=%0d want 2", count);
    else pass_cnt++;
    step();
    step();
    total++;
    if (count !== 8'd0 || done !== 1'b1)
      $display("FAIL b2b_done: count=%0d done=%b want 0 1", count, done);
    else pass_cnt++;
  endtask

  task automatic test_restart_terminal();
    kick(8'd2, 4'd0, 1'b0);
    step();
    kick(8'd4, 4'd0, 1'b0);
    total++;
    if (count !== 8'd4 || done !== 1'b0 || expired !== 1'b0 || busy !== 1'b1)
      $display("FAIL restart_term: count=%0d done=%b exp=%b busy=%b want 4 0 0 1",
               count, done, expired, busy);
    else pass_cnt++;
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    load_val    = '0;
    prescale    = '0;
    start       = 1'b0;
    stop        = 1'b0;
    pause       = 1'b0;
    auto_reload = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    test_reset();
    test_one_shot();
    test_prescaled();
    test_long();
    test_periodic();
    test_pause();
    test_start_stop();
    test_zero_load();
    test_back_to_back();
    test_restart_terminal();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with prescaler, start/stop/pause control and a terminal-count pulse. It is the counting-down counterpart of the team's free-running 8-bit up-counter. Software or an FSM loads a value and starts it. The block decrements once per prescaled tick and flags expiry, optionally reloading for periodic operation. It sits beside the up-counter in the sequential library as the general-purpose timeout/period generator.

## Interface
- WIDTH, 8: width of load value and count.
- PS_W, 4: width of prescale field.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- load_val  in  WIDTH  start value, sampled on accepted start.
- prescale  in  PS_W  tick every prescale+1 enabled cycles; sampled on accepted start.
- start  in  1  one-cycle request: load and run. Restarts if already running.
- stop  in  1  abort run. No done is generated.
- pause  in  1  level; while high in RUN, prescaler and count freeze.
- auto_reload  in  1  level; sampled on accepted start; periodic mode.
- count  out  WIDTH  current count value.
- busy  out  1  high in RUN, including while paused.
- done  out  1  one-cycle pulse on terminal count.
- expired  out  1  sticky; set with done, cleared by accepted start or rst.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Priority on each edge: rst > stop > start > tick.
- rst: state=IDLE, count=0, prescaler=0, done=0, expired=0, busy=0, latched reload value/prescale/auto_reload=0.
- stop (any state): state=IDLE, count=0, prescaler=0, done=0. expired is unchanged. start in the same cycle is ignored.
- Accepted start (no stop):
  - Latches load_val, prescale and auto_reload.
  - count=load_val, prescaler=0, expired=0.
  - If load_val≠0: state=RUN.
  - If load_val=0: state stays/returns IDLE; done=1 and expired=1 on the next edge.
- RUN, pause=0:
  - If prescaler≠latched prescale, prescaler+1.
  - Else prescaler=0 and a tick occurs.
- Tick with count>1: count−1.
- Tick with count=1 (terminal):
  - done=1 and expired=1 for that cycle.
  - If latched auto_reload=0: count=0, state=IDLE.
  - If latched auto_reload=1: count=latched load value, stays RUN. count never shows 0.
- RUN, pause=1: no prescaler or count change; busy stays 1.
- pause is ignored in IDLE.
- start with pause=1 loads, and no tick occurs until pause=0.
- Arithmetic: count never decrements below 0; no wrap. prescaler is compared as unsigned PS_W bits.
- done is a registered pulse, high exactly one cycle per terminal event. It is never asserted by stop or rst.
- auto_reload changes mid-run have no effect until the next accepted start.

## Timing
- All outputs registered; no combinational input→output paths.
- Start sampled at edge k: count=L and busy=1 visible after edge k.
- First tick at edge k+(P+1); the count reaches terminal after L ticks.
- Without pause, done and count=0 are visible after edge k+L·(P+1); busy falls on the same edge.
- Periodic mode: done every L·(P+1) cycles, first one at k+L·(P+1).
- Each cycle with pause=1 in RUN delays every later event by exactly one cycle.
- start on the same edge as a terminal tick: start wins. The block reloads, no done is issued, expired is cleared.
- rst mid-run: all outputs at reset values after that edge. No done.
- Back-to-back start on consecutive cycles: each restarts. Only the last load_val is effective.

## Test plan
- Reset: rst=1 for 2 cycles mid-run → count=0, busy=0, done=0, expired=0 after first reset edge.
- One-shot: load_val=3, prescale=0, start 1 cycle → count 3,2,1,0 on consecutive edges. done=1 only with count=0. busy falls on the same edge; expired stays 1.
- Prescaled: load_val=2, prescale=3 → count changes every 4 cycles; done exactly 8 cycles after start edge. load_val=255, prescale=0 → done after 255 cycles, no underflow.
- Periodic: auto_reload=1, load_val=3, prescale=0 → count 3,2,1,3,2,1…, done pulses every 3 cycles, busy stays 1. stop → IDLE, count=0, no done.
- Pause/priority: load_val=4, prescale=0, pause high 5 cycles mid-run → count frozen, done delayed by exactly 5 cycles. start and stop in the same cycle → IDLE, count=0.
- Zero load: load_val=0, start → busy never 1; done=1 and expired=1 one cycle after start edge. A later start clears expired.
